// File: rtl/div_err_monitor.sv
// Scores a 16/8 approximate divider against exact restoring division and keeps
// saturating error statistics for characterisation runs.
module div_err_monitor #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SUM_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [7:0]       in_y,
  input  logic [7:0]       in_q,
  input  logic [7:0]       in_r,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic             last_skip,
  output logic             last_err,
  output logic [7:0]       last_ed,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] rem_err_cnt,
  output logic [SUM_W-1:0] ed_sum,
  output logic [7:0]       ed_max
);

  typedef enum logic [1:0] {StIdle, StRun, StCmp} state_e;

  state_e           state_q, state_d;
  logic [15:0]      x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [7:0]       q_q, q_d;
  logic [7:0]       r_q, r_d;
  logic             skip_q, skip_d;
  logic [8:0]       rem_q, rem_d;
  logic [2:0]       k_q, k_d;
  logic [7:0]       qex_q, qex_d;
  logic             done_q, done_d;
  logic             lskip_q, lskip_d;
  logic             lerr_q, lerr_d;
  logic [7:0]       led_q, led_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] skipc_q, skipc_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] remerr_q, remerr_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       max_q, max_d;

  logic             accept;
  logic [8:0]       shifted;
  logic [9:0]       diff;
  logic             qbit;
  logic [7:0]       ed;
  logic [SUM_W:0]   sum_ext;

  assign in_ready = rst_n && (state_q == StIdle);
  assign accept   = in_valid && in_ready;

  // One restoring step: the borrow out of the 10-bit subtract decides the bit.
  assign shifted = {rem_q[7:0], x_q[k_q]};
  assign diff    = {1'b0, shifted} - {2'b00, y_q};
  assign qbit    = ~diff[9] | rem_q[8];

  assign ed      = (qex_q >= q_q) ? (qex_q - q_q) : (q_q - qex_q);
  assign sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(ed);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    q_d      = q_q;
    r_d      = r_q;
    skip_d   = skip_q;
    rem_d    = rem_q;
    k_d      = k_q;
    qex_d    = qex_q;
    done_d   = 1'b0;
    lskip_d  = lskip_q;
    lerr_d   = lerr_q;
    led_d    = led_q;
    sample_d = sample_q;
    skipc_d  = skipc_q;
    err_d    = err_q;
    remerr_d = remerr_q;
    sum_d    = sum_q;
    max_d    = max_q;

    if (clr && state_q != StCmp) begin
      lskip_d  = 1'b0;
      lerr_d   = 1'b0;
      led_d    = '0;
      sample_d = '0;
      skipc_d  = '0;
      err_d    = '0;
      remerr_d = '0;
      sum_d    = '0;
      max_d    = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_d = in_x;
          y_d = in_y;
          q_d = in_q;
          r_d = in_r;
          if (in_y == 8'd0 || in_x[15:8] >= in_y) begin
            skip_d  = 1'b1;
            state_d = StCmp;
          end else begin
            skip_d  = 1'b0;
            rem_d   = {1'b0, in_x[15:8]};
            k_d     = 3'd7;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        qex_d = {qex_q[6:0], qbit};
        rem_d = qbit ? diff[8:0] : shifted;
        if (k_q == 3'd0) state_d = StCmp;
        else             k_d = k_q - 3'd1;
      end
      StCmp: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (skip_q) begin
          lskip_d = 1'b1;
          lerr_d  = 1'b0;
          led_d   = '0;
          if (skipc_q != '1) skipc_d = skipc_q + 1'b1;
        end else begin
          lskip_d = 1'b0;
          lerr_d  = (ed != 8'd0);
          led_d   = ed;
          if (sample_q != '1) sample_d = sample_q + 1'b1;
          if (ed != 8'd0 && err_q != '1) err_d = err_q + 1'b1;
          if (r_q != rem_q[7:0] && remerr_q != '1) remerr_d = remerr_q + 1'b1;
          sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
          if (ed > max_q) max_d = ed;
        end
        // A clear landing on the finishing edge wins for the accumulators only.
        if (clr) begin
          sample_d = '0;
          skipc_d  = '0;
          err_d    = '0;
          remerr_d = '0;
          sum_d    = '0;
          max_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      skip_q   <= 1'b0;
      rem_q    <= '0;
      k_q      <= '0;
      qex_q    <= '0;
      done_q   <= 1'b0;
      lskip_q  <= 1'b0;
      lerr_q   <= 1'b0;
      led_q    <= '0;
      sample_q <= '0;
      skipc_q  <= '0;
      err_q    <= '0;
      remerr_q <= '0;
      sum_q    <= '0;
      max_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      q_q      <= q_d;
      r_q      <= r_d;
      skip_q   <= skip_d;
      rem_q    <= rem_d;
      k_q      <= k_d;
      qex_q    <= qex_d;
      done_q   <= done_d;
      lskip_q  <= lskip_d;
      lerr_q   <= lerr_d;
      led_q    <= led_d;
      sample_q <= sample_d;
      skipc_q  <= skipc_d;
      err_q    <= err_d;
      remerr_q <= remerr_d;
      sum_q    <= sum_d;
      max_q    <= max_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign last_skip   = lskip_q;
  assign last_err    = lerr_q;
  assign last_ed     = led_q;
  assign sample_cnt  = sample_q;
  assign skip_cnt    = skipc_q;
  assign err_cnt     = err_q;
  assign rem_err_cnt = remerr_q;
  assign ed_sum      = sum_q;
  assign ed_max      = max_q;

endmodule

// File: tb/tb_div_err_monitor.sv
// Bench for div_err_monitor: a transaction-level model (plain / and %, unbounded
// counts clamped per instance width) checked every cycle against two DUT widths.
module tb_div_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, clr;
  logic [15:0] in_x;
  logic [7:0]  in_y, in_q, in_r;

  always #5 clk = ~clk;

  logic        rdy_a, busy_a, done_a, lskip_a, lerr_a;
  logic [7:0]  led_a, max_a;
  logic [31:0] smp_a, skp_a, err_a, rer_a;
  logic [39:0] sum_a;

  logic        rdy_b, busy_b, done_b, lskip_b, lerr_b;
  logic [7:0]  led_b, max_b;
  logic [3:0]  smp_b, skp_b, err_b, rer_b;
  logic [5:0]  sum_b;

  div_err_monitor #(.CNT_W(32), .SUM_W(40)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_x(in_x), .in_y(in_y),
    .in_q(in_q), .in_r(in_r), .clr(clr), .busy(busy_a), .done(done_a), .last_skip(lskip_a),
    .last_err(lerr_a), .last_ed(led_a), .sample_cnt(smp_a), .skip_cnt(skp_a), .err_cnt(err_a),
    .rem_err_cnt(rer_a), .ed_sum(sum_a), .ed_max(max_a)
  );

  div_err_monitor #(.CNT_W(4), .SUM_W(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_x(in_x), .in_y(in_y),
    .in_q(in_q), .in_r(in_r), .clr(clr), .busy(busy_b), .done(done_b), .last_skip(lskip_b),
    .last_err(lerr_b), .last_ed(led_b), .sample_cnt(smp_b), .skip_cnt(skp_b), .err_cnt(err_b),
    .rem_err_cnt(rer_b), .ed_sum(sum_b), .ed_max(max_b)
  );

  int n_vec = 0;
  int n_fail = 0;

  // Model state
  bit     m_busy, m_done, m_acc, p_skip, m_lskip, m_lerr;
  int     m_left, p_x, p_y, p_q, p_r, m_led, m_max;
  longint m_smp, m_skp, m_err, m_rer, m_sum;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic model_edge();
    bit was_busy, fin;
    int qe, re, ed;
    was_busy = m_busy;
    m_acc    = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_left = 0;
      m_lskip = 0; m_lerr = 0; m_led = 0; m_max = 0;
      m_smp = 0; m_skp = 0; m_err = 0; m_rer = 0; m_sum = 0;
      return;
    end
    fin = was_busy && (m_left == 1);
    m_done = fin;
    if (fin) begin
      m_busy = 0;
      m_left = 0;
      if (p_skip) begin
        m_skp++; m_lskip = 1; m_lerr = 0; m_led = 0;
      end else begin
        qe = p_x / p_y;
        re = p_x % p_y;
        ed = (qe > p_q) ? qe - p_q : p_q - qe;
        m_smp++; m_lskip = 0; m_lerr = (ed != 0); m_led = ed;
        if (ed != 0) m_err++;
        if (re != p_r) m_rer++;
        m_sum += ed;
        if (ed > m_max) m_max = ed;
      end
      if (clr) begin
        m_smp = 0; m_skp = 0; m_err = 0; m_rer = 0; m_sum = 0; m_max = 0;
      end
    end else begin
      if (was_busy) m_left--;
      if (clr) begin
        m_smp = 0; m_skp = 0; m_err = 0; m_rer = 0; m_sum = 0; m_max = 0;
        m_lskip = 0; m_lerr = 0; m_led = 0;
      end
    end
    if (in_valid && !was_busy) begin
      m_acc  = 1'b1;
      p_x = in_x; p_y = in_y; p_q = in_q; p_r = in_r;
      p_skip = (in_y == 0) || ((in_x >> 8) >= in_y);
      m_left = p_skip ? 1 : 9;
      m_busy = 1;
    end
  endtask

  task automatic compare();
    check("in_ready_a", rdy_a, rst_n && !m_busy);
    check("in_ready_b", rdy_b, rst_n && !m_busy);
    check("busy_a", busy_a, m_busy);
    check("busy_b", busy_b, m_busy);
    check("done_a", done_a, m_done);
    check("done_b", done_b, m_done);
    check("last_skip_a", lskip_a, m_lskip);
    check("last_skip_b", lskip_b, m_lskip);
    check("last_err_a", lerr_a, m_lerr);
    check("last_err_b", lerr_b, m_lerr);
    check("last_ed_a", led_a, m_led);
    check("last_ed_b", led_b, m_led);
    check("ed_max_a", max_a, m_max);
    check("ed_max_b", max_b, m_max);
    check("sample_cnt_a", smp_a, sat(m_smp, 32));
    check("sample_cnt_b", smp_b, sat(m_smp, 4));
    check("skip_cnt_a", skp_a, sat(m_skp, 32));
    check("skip_cnt_b", skp_b, sat(m_skp, 4));
    check("err_cnt_a", err_a, sat(m_err, 32));
    check("err_cnt_b", err_b, sat(m_err, 4));
    check("rem_err_cnt_a", rer_a, sat(m_rer, 32));
    check("rem_err_cnt_b", rer_b, sat(m_rer, 4));
    check("ed_sum_a", sum_a, sat(m_sum, 40));
    check("ed_sum_b", sum_b, sat(m_sum, 6));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_a && n < 20);
    if (!done_a) begin
      n_vec++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", n);
    end
  endtask

  task automatic drive(input logic [15:0] x, input logic [7:0] y, input logic [7:0] q,
                       input logic [7:0] r);
    in_x = x; in_y = y; in_q = q; in_r = r;
  endtask

  task automatic run_sample(input logic [15:0] x, input logic [7:0] y, input logic [7:0] q,
                            input logic [7:0] r, input int lat);
    int n;
    drive(x, y, q, r);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(n);
    if (lat >= 0) check("latency", n, lat);
  endtask

  typedef struct { logic [15:0] x; logic [7:0] y, q, r; } vec_t;
  vec_t tbl[3];
  int   acc_t[3];
  int   na, n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
    drive(16'h0, 8'h0, 8'h0, 8'h0);
    repeat (3) tick();
    check("reset_busy", busy_a, 0);
    check("reset_ready_low", rdy_a, 0);
    rst_n = 1'b1;
    tick();
    check("post_reset_ready", rdy_a, 1);
    check("post_reset_sample_cnt", smp_a, 0);

    // Exact hit: 0x1234 / 0x56 = 54 r 16
    run_sample(16'h1234, 8'h56, 8'd54, 8'd16, 9);
    check("a_sample_cnt", smp_a, 1);
    check("a_err_cnt", err_a, 0);
    check("a_rem_err_cnt", rer_a, 0);
    check("a_ed_sum", sum_a, 0);

    run_sample(16'h1234, 8'h56, 8'd50, 8'd16, 9);
    check("b_last_err", lerr_a, 1);
    check("b_last_ed", led_a, 4);
    check("b_err_cnt", err_a, 1);
    check("b_ed_sum", sum_a, 4);
    check("b_ed_max", max_a, 4);
    run_sample(16'h1234, 8'h56, 8'd56, 8'd16, 9);
    check("c_ed_sum", sum_a, 6);
    check("c_ed_max", max_a, 4);

    run_sample(16'h1234, 8'h00, 8'd0, 8'd0, 1);
    run_sample(16'hFF00, 8'h10, 8'd0, 8'd0, 1);
    check("skip_cnt", skp_a, 2);
    check("skip_sample_cnt", smp_a, 3);
    check("skip_last_skip", lskip_a, 1);

    tbl[0] = '{x: 16'hFEFF, y: 8'hFF, q: 8'd255, r: 8'd254};
    tbl[1] = '{x: 16'h00FF, y: 8'h01, q: 8'd255, r: 8'd0};
    tbl[2] = '{x: 16'h7FFF, y: 8'h80, q: 8'd255, r: 8'd126};
    foreach (tbl[i]) run_sample(tbl[i].x, tbl[i].y, tbl[i].q, tbl[i].r, 9);
    check("tbl_rem_err_cnt", rer_a, 1);

    // Reset while RUN is at k=3
    drive(16'h1234, 8'h56, 8'd54, 8'd16);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy_a, 0);
    check("midrst_sample_cnt", smp_a, 0);
    check("midrst_ed_sum", sum_a, 0);
    rst_n = 1'b1;
    run_sample(16'h1234, 8'h56, 8'd54, 8'd16, 9);
    check("postrst_sample_cnt", smp_a, 1);
    check("postrst_err_cnt", err_a, 0);

    // in_valid held high across three samples
    na = 0;
    drive(tbl[0].x, tbl[0].y, tbl[0].q, tbl[0].r);
    in_valid = 1'b1;
    for (int c = 0; c < 60 && na < 3; c++) begin
      tick();
      if (m_acc) begin
        acc_t[na] = c;
        na++;
        if (na < 3) drive(tbl[na].x, tbl[na].y, tbl[na].q, tbl[na].r);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("held_accepts", na, 3);
    check("held_gap0", acc_t[1] - acc_t[0], 10);
    check("held_gap1", acc_t[2] - acc_t[1], 10);
    wait_done(n);

    // clr during RUN does not abort; then drive the narrow instance into saturation
    drive(16'h1234, 8'h56, 8'd0, 8'd16);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_done(n);
    check("clrrun_sample_cnt", smp_a, 1);
    check("clrrun_ed_sum_b", sum_b, 54);
    repeat (16) run_sample(16'h1234, 8'h56, 8'd0, 8'd16, -1);
    check("sat_err_cnt_b", err_b, 15);
    check("sat_sample_cnt_b", smp_b, 15);
    check("sat_ed_sum_b", sum_b, 63);
    check("sat_err_cnt_a", err_a, 17);
    check("sat_ed_sum_a", sum_a, 918);

    // clr coincident with the CMP edge
    drive(16'h1234, 8'h56, 8'd50, 8'd16);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("cmpclr_done", done_a, 1);
    check("cmpclr_sample_cnt", smp_a, 0);
    check("cmpclr_err_cnt_b", err_b, 0);
    check("cmpclr_ed_sum", sum_a, 0);
    check("cmpclr_ed_max", max_a, 0);
    check("cmpclr_last_ed", led_a, 4);
    check("cmpclr_last_err", lerr_a, 1);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
